// File: rtl/if_stage_pkg.sv
// Shared CPU constants and types used by the instruction-fetch stage.
package if_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    localparam int IMM16_MSB = 15;
    localparam int IMM16_LSB = 0;
    localparam int INDEX_MSB = 25;
    localparam int INDEX_LSB = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc: 32'h0, pc4: 32'h0, valid: 1'b0};

endpackage

// File: rtl/if_stage_if.sv
// Bundle of fetch-stage control inputs, instruction memory port and IF/ID outputs.
interface if_stage_if;

    logic        stall;
    logic        id_is_b;
    logic        is_branch;
    logic        id_is_j;
    logic        id_is_jr;
    logic [31:0] jr_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic        id_valid;

    modport master (
        input  stall, id_is_b, is_branch, id_is_j, id_is_jr, jr_target, imem_rdata,
        output imem_addr, id_instr, id_pc, id_pc4, id_valid
    );

    modport slave (
        output stall, id_is_b, is_branch, id_is_j, id_is_jr, jr_target, imem_rdata,
        input  imem_addr, id_instr, id_pc, id_pc4, id_valid
    );

endinterface

// File: rtl/if_stage_npc.sv
// Combinational next-PC logic: decides whether the ID instruction redirects fetch and where to.
module npc
    import if_stage_pkg::*;
(
    input  logic [31:0] id_pc4,
    input  logic [31:0] id_instr,
    input  logic        id_valid,
    input  logic        id_is_b,
    input  logic        is_branch,
    input  logic        id_is_j,
    input  logic        id_is_jr,
    input  logic [31:0] jr_target,
    output logic        redirect,
    output logic [31:0] target
);

    logic [31:0] b_offset;
    logic [31:0] b_target;
    logic [31:0] j_target;
    logic        unused_opcode;

    assign b_offset = {{14{id_instr[IMM16_MSB]}}, id_instr[IMM16_MSB:IMM16_LSB], 2'b00};
    assign b_target = id_pc4 + b_offset;
    assign j_target = {id_pc4[31:28], id_instr[INDEX_MSB:INDEX_LSB], 2'b00};

    assign unused_opcode = ^id_instr[31:26];

    // jr outranks j, which outranks b, should the decoder ever assert several
    always_comb begin
        target = b_target;
        if (id_is_jr) begin
            target = jr_target;
        end else if (id_is_j) begin
            target = j_target;
        end
    end

    assign redirect = id_valid & (id_is_jr | id_is_j | (id_is_b & is_branch));

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC priority mux and IF/ID pipeline register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic      clk,
    input  logic      reset,
    if_stage_if.master bus
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic        redirect;
    ifid_t       ifid;

    assign pc_plus4 = pc + 32'd4;

    npc u_npc (
        .id_pc4    (ifid.pc4),
        .id_instr  (ifid.instr),
        .id_valid  (ifid.valid),
        .id_is_b   (bus.id_is_b),
        .is_branch (bus.is_branch),
        .id_is_j   (bus.id_is_j),
        .id_is_jr  (bus.id_is_jr),
        .jr_target (bus.jr_target),
        .redirect  (redirect),
        .target    (target)
    );

    // A stalled cycle drops any redirect; it is re-evaluated from the held IF/ID next cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            pc   <= RESET_PC;
            ifid <= IFID_BUBBLE;
        end else if (bus.stall) begin
            pc   <= pc;
            ifid <= ifid;
        end else if (redirect) begin
            pc   <= target;
            ifid <= IFID_BUBBLE;
        end else begin
            pc   <= pc_plus4;
            ifid <= '{instr: bus.imem_rdata, pc: pc, pc4: pc_plus4, valid: 1'b1};
        end
    end

    assign bus.imem_addr = pc;
    assign bus.id_instr  = ifid.instr;
    assign bus.id_pc     = ifid.pc;
    assign bus.id_pc4    = ifid.pc4;
    assign bus.id_valid  = ifid.valid;

endmodule

// File: tb/tb_if_stage.sv
// Directed, table-driven bench for if_stage with hand-written stall, priority, wrap and reset sequences.
module tb_if_stage;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    if_stage_if bus();

    if_stage #(.RESET_PC(32'h0000_3000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [4:0]  ctrl;
        logic [31:0] jr_target;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
        logic [31:0] exp_pc4;
        logic        exp_valid;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(input logic [4:0] ctrl, input logic [31:0] jt, input logic [31:0] rd,
                                input logic [31:0] ea, input logic [31:0] ei, input logic [31:0] ep,
                                input logic [31:0] ep4, input logic ev);
        vec_t v;
        v.ctrl      = ctrl;
        v.jr_target = jt;
        v.rdata     = rd;
        v.exp_addr  = ea;
        v.exp_instr = ei;
        v.exp_pc    = ep;
        v.exp_pc4   = ep4;
        v.exp_valid = ev;
        return v;
    endfunction

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] ea, input logic [31:0] ei,
                               input logic [31:0] ep, input logic [31:0] ep4, input logic ev);
        checkField({tag, " imem_addr"}, bus.imem_addr, ea);
        checkField({tag, " id_instr"},  bus.id_instr,  ei);
        checkField({tag, " id_pc"},     bus.id_pc,     ep);
        checkField({tag, " id_pc4"},    bus.id_pc4,    ep4);
        checkField({tag, " id_valid"},  {31'b0, bus.id_valid}, {31'b0, ev});
    endtask

    // ctrl bits are {stall, id_is_b, is_branch, id_is_j, id_is_jr}
    task automatic applyStimulus(input logic [4:0] ctrl, input logic [31:0] jt, input logic [31:0] rd);
        {bus.stall, bus.id_is_b, bus.is_branch, bus.id_is_j, bus.id_is_jr} = ctrl;
        bus.jr_target  = jt;
        bus.imem_rdata = rd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = mk(5'b00000, 32'h0,    32'h2408_0001, 32'h3004, 32'h2408_0001, 32'h3000, 32'h3004, 1'b1);
        vecs[1]  = mk(5'b00000, 32'h0,    32'h2409_0002, 32'h3008, 32'h2409_0002, 32'h3004, 32'h3008, 1'b1);
        vecs[2]  = mk(5'b00000, 32'h0,    32'h1000_FFFE, 32'h300C, 32'h1000_FFFE, 32'h3008, 32'h300C, 1'b1);
        vecs[3]  = mk(5'b01100, 32'h0,    32'hDEAD_BEEF, 32'h3004, 32'h0,         32'h0,    32'h0,    1'b0);
        vecs[4]  = mk(5'b01100, 32'h0,    32'h2409_0002, 32'h3008, 32'h2409_0002, 32'h3004, 32'h3008, 1'b1);
        vecs[5]  = mk(5'b00000, 32'h0,    32'h0800_0C10, 32'h300C, 32'h0800_0C10, 32'h3008, 32'h300C, 1'b1);
        vecs[6]  = mk(5'b00010, 32'h0,    32'hDEAD_BEEF, 32'h3040, 32'h0,         32'h0,    32'h0,    1'b0);
        vecs[7]  = mk(5'b00000, 32'h0,    32'h1400_0003, 32'h3044, 32'h1400_0003, 32'h3040, 32'h3044, 1'b1);
        vecs[8]  = mk(5'b01000, 32'h0,    32'h0080_0008, 32'h3048, 32'h0080_0008, 32'h3044, 32'h3048, 1'b1);
        vecs[9]  = mk(5'b00001, 32'h3100, 32'hDEAD_BEEF, 32'h3100, 32'h0,         32'h0,    32'h0,    1'b0);
        vecs[10] = mk(5'b00000, 32'h0,    32'h1000_0004, 32'h3104, 32'h1000_0004, 32'h3100, 32'h3104, 1'b1);

        reset = 1'b1;
        {bus.stall, bus.id_is_b, bus.is_branch, bus.id_is_j, bus.id_is_jr} = 5'b0;
        bus.jr_target  = 32'h0;
        bus.imem_rdata = 32'h2408_0001;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("reset", 32'h3000, 32'h0, 32'h0, 32'h0, 1'b0);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].ctrl, vecs[i].jr_target, vecs[i].rdata);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_addr, vecs[i].exp_instr,
                        vecs[i].exp_pc, vecs[i].exp_pc4, vecs[i].exp_valid);
        end

        // Held beq at 0x3100 (imm 4) targets 0x3114 once the stall lifts
        for (int k = 0; k < 3; k++) begin
            applyStimulus(5'b11100, 32'h0, 32'hDEAD_BEEF);
            checkOutput($sformatf("stall%0d", k), 32'h3104, 32'h1000_0004, 32'h3100, 32'h3104, 1'b1);
        end
        applyStimulus(5'b01100, 32'h0, 32'hDEAD_BEEF);
        checkOutput("stall_release", 32'h3114, 32'h0, 32'h0, 32'h0, 1'b0);

        applyStimulus(5'b00000, 32'h0, 32'h0800_0C10);
        checkOutput("prio_fetch1", 32'h3118, 32'h0800_0C10, 32'h3114, 32'h3118, 1'b1);
        applyStimulus(5'b01111, 32'h3200, 32'hDEAD_BEEF);
        checkOutput("prio_jr", 32'h3200, 32'h0, 32'h0, 32'h0, 1'b0);

        applyStimulus(5'b00000, 32'h0, 32'h0800_0C10);
        checkOutput("prio_fetch2", 32'h3204, 32'h0800_0C10, 32'h3200, 32'h3204, 1'b1);
        applyStimulus(5'b01110, 32'h0, 32'hDEAD_BEEF);
        checkOutput("prio_j", 32'h3040, 32'h0, 32'h0, 32'h0, 1'b0);

        applyStimulus(5'b00000, 32'h0, 32'h0080_0008);
        checkOutput("wrap_fetch", 32'h3044, 32'h0080_0008, 32'h3040, 32'h3044, 1'b1);
        applyStimulus(5'b00001, 32'hFFFF_FFFC, 32'hDEAD_BEEF);
        checkOutput("wrap_jr", 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0, 1'b0);
        applyStimulus(5'b00000, 32'h0, 32'h2408_0001);
        checkOutput("wrap_seq", 32'h0000_0000, 32'h2408_0001, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1);

        // beq -1 at address 0: target wraps 4 + 0xFFFFFFFC back onto itself
        applyStimulus(5'b00000, 32'h0, 32'h1000_FFFF);
        checkOutput("self_fetch", 32'h4, 32'h1000_FFFF, 32'h0, 32'h4, 1'b1);
        applyStimulus(5'b01100, 32'h0, 32'hDEAD_BEEF);
        checkOutput("self_loop", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);

        applyStimulus(5'b00000, 32'h0, 32'h2408_0001);
        checkOutput("pre_reset", 32'h4, 32'h2408_0001, 32'h0, 32'h4, 1'b1);
        reset = 1'b1;
        applyStimulus(5'b10001, 32'h3100, 32'hDEAD_BEEF);
        checkOutput("reset_mid_stall", 32'h3000, 32'h0, 32'h0, 32'h0, 1'b0);
        reset = 1'b0;
        applyStimulus(5'b00000, 32'h0, 32'h2408_0001);
        checkOutput("post_reset", 32'h3004, 32'h2408_0001, 32'h3000, 32'h3004, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the dynamic pipeline CPU: holds the PC, selects the next PC, and drives the IF/ID pipeline register. The ID stage resolves beq/bne through the branch comparator, whose `is_branch` result comes back here to redirect fetch. j/jal/jr are also resolved in ID. Taken control transfers redirect the PC and flush the wrong-path instruction in IF/ID; there is no delay slot.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC value after reset.
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `stall`  in  1: from the hazard unit; holds PC and IF/ID.
- `id_is_b`  in  1: ID instruction is beq/bne.
- `is_branch`  in  1: comparator result for the ID instruction.
- `id_is_j`  in  1: ID instruction is j/jal.
- `id_is_jr`  in  1: ID instruction is jr.
- `jr_target`  in  32: forwarded rs value for jr.
- `imem_addr`  out  32: instruction memory address; equals PC.
- `imem_rdata`  in  32: combinational instruction read of `imem_addr`.
- `id_instr`  out  32: IF/ID instruction.
- `id_pc`  out  32: IF/ID PC.
- `id_pc4`  out  32: IF/ID PC+4, used as the jal link value.
- `id_valid`  out  1: IF/ID holds a real instruction.

## Operation
- Registers:
  - PC.
  - IF/ID: `id_instr`, `id_pc`, `id_pc4`, `id_valid`.
- Reset values:
  - PC = `RESET_PC`.
  - `id_instr` = 0 (nop), `id_pc` = 0, `id_pc4` = 0, `id_valid` = 0.
- Control inputs are ignored when `id_valid` = 0.
- The decoder guarantees `id_is_b`, `id_is_j` and `id_is_jr` are mutually exclusive. If more than one is asserted, priority is jr > j > b.
- Redirect target, computed from IF/ID contents (32-bit arithmetic, wrap-around with no trap):
  - b taken (`id_is_b` & `is_branch`): `id_pc4 + (sext(id_instr[15:0]) << 2)`.
  - j/jal: `{id_pc4[31:28], id_instr[25:0], 2'b00}`.
  - jr: `jr_target`, used as-is; alignment is not checked.
- `redirect` = `id_valid` & (jr | j | (`id_is_b` & `is_branch`)).
- Per-cycle update, in priority order:
  1. `reset`: load the reset values.
  2. `stall`: PC and IF/ID hold. `redirect` is ignored; it is re-evaluated next cycle with the same IF/ID contents.
  3. `redirect`:
     - PC loads the target.
     - IF/ID loads a bubble: `id_instr` = 0, `id_valid` = 0, `id_pc` and `id_pc4` = 0.
  4. Otherwise:
     - PC loads PC+4.
     - IF/ID loads {`imem_rdata`, PC, PC+4, 1}.
- A not-taken b (`is_branch` = 0) is sequential fetch; no flush.
- A branch or jump targeting itself loops indefinitely; no special case.

## Timing
- Fetch latency: one cycle from PC to `id_instr`. `imem_addr` is combinational from the PC register.
- Redirect penalty: one bubble.
  - Cycle n: branch in ID, redirect asserted.
  - Cycle n+1: PC = target, IF/ID = bubble.
  - Cycle n+2: target instruction in ID.
- First cycle after reset deasserts: `imem_addr` = `RESET_PC`, `id_valid` = 0. The first valid `id_instr` appears one cycle later.
- Reset asserted mid-stall or mid-redirect: reset wins that edge.
- `is_branch` and `jr_target` are combinational from ID. They must settle within the cycle; no internal registering.

## Structure
- The shared CPU package holds:
  - `RESET_PC_DEFAULT` = 32'h0000_3000.
  - `NOP_INSTR` = 32'h0.
  - Field-slice constants: imm16 [15:0], instr_index [25:0].
- One combinational sub-module, `npc`: inputs are `id_pc4`, `id_instr`, the control flags and `jr_target`; outputs are `redirect` and `target`. `if_stage` holds only the registers and the priority mux.

## Test plan
- Reset sequence:
  - Stimulus: assert `reset` 2 cycles with `imem_rdata` = 32'h2408_0001, then release.
  - Required: `imem_addr` = 0x3000 and `id_valid` = 0 on release; next cycle `id_instr` = 0x24080001, `id_pc` = 0x3000, `id_pc4` = 0x3004, PC = 0x3004.
- Taken beq:
  - Stimulus: `id_pc` = 0x3008, imm16 = 0xFFFE, `id_is_b` = 1, `is_branch` = 1.
  - Required: PC = 0x3004 next cycle, `id_valid` = 0, `id_instr` = 0.
- Not-taken bne:
  - Stimulus: `is_branch` = 0.
  - Required: PC advances by 4, no bubble.
- j and jr:
  - j with `id_pc4` = 0x300C, instr_index = 0x0000C10 → PC = 0x3040.
  - jr with `jr_target` = 0x3100 → PC = 0x3100; one bubble each.
- Stall with pending redirect:
  - Stimulus: `stall` = 1 for 3 cycles while `redirect` conditions hold, then `stall` = 0.
  - Required: PC and IF/ID unchanged during the stall; redirect occurs on the first unstalled edge.
- Wrap-around:
  - Stimulus: PC = 0xFFFF_FFFC with no control input.
  - Required: next PC = 0x0000_0000.
  - Stimulus: `id_is_b` = 1, `is_branch` = 1 while `id_valid` = 0.
  - Required: no redirect.
